// File: rtl/ram_fifo_ctrl.sv
// Pointer/occupancy controller that wraps a registered-read dual-port RAM into a
// valid/ready flit FIFO; the RAM's dataOut register is the FIFO output stage.
module ram_fifo_ctrl #(
  parameter int addressWidth     = 4,
  parameter int almostFullThresh = 2**addressWidth - 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    inValid,
  output logic                    inReady,
  output logic                    outValid,
  input  logic                    outReady,
  output logic                    writeEn,
  output logic [addressWidth-1:0] writeAddr,
  output logic                    readEn,
  output logic [addressWidth-1:0] readAddr,
  output logic [addressWidth:0]   memCount,
  output logic                    almostFull,
  output logic                    empty
);

  localparam logic [addressWidth:0] capacity  = {1'b1, {addressWidth{1'b0}}};
  localparam logic [addressWidth:0] threshVal = almostFullThresh[addressWidth:0];

  logic [addressWidth-1:0] wrPtr;
  logic [addressWidth-1:0] rdPtr;
  logic [addressWidth:0]   memCountNext;
  logic                    outValidNext;
  logic                    full;

  // full is decoded from registered state only, so inReady never depends on inputs
  assign full      = (memCount == capacity);
  assign inReady   = !full && !reset;
  assign writeEn   = inValid && inReady;
  assign readEn    = (memCount != '0) && (!outValid || outReady) && !reset;
  assign writeAddr = wrPtr;
  assign readAddr  = rdPtr;
  assign empty     = (memCount == '0) && !outValid;

  always_comb begin
    memCountNext = memCount;
    if (writeEn && !readEn) begin
      memCountNext = memCount + 1'b1;
    end else if (readEn && !writeEn) begin
      memCountNext = memCount - 1'b1;
    end
  end

  // A RAM read refills the output stage; otherwise a downstream take empties it
  always_comb begin
    outValidNext = outValid;
    if (readEn) begin
      outValidNext = 1'b1;
    end else if (outReady) begin
      outValidNext = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      memCount   <= '0;
      outValid   <= 1'b0;
      almostFull <= 1'b0;
    end else begin
      if (writeEn) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (readEn) begin
        rdPtr <= rdPtr + 1'b1;
      end
      memCount   <= memCountNext;
      outValid   <= outValidNext;
      almostFull <= (memCountNext >= threshVal);
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed and scoreboard checks of ram_fifo_ctrl driving a behavioural registered-read RAM.
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       inValid;
  logic       inReady;
  logic       outValid;
  logic       outReady;
  logic       writeEn;
  logic [3:0] writeAddr;
  logic       readEn;
  logic [3:0] readAddr;
  logic [4:0] memCount;
  logic       almostFull;
  logic       empty;
  logic [7:0] inData;
  logic [7:0] dataOut;
  logic [7:0] ramMem [0:15];

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.addressWidth(4)) dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
    .outValid(outValid), .outReady(outReady), .writeEn(writeEn),
    .writeAddr(writeAddr), .readEn(readEn), .readAddr(readAddr),
    .memCount(memCount), .almostFull(almostFull), .empty(empty)
  );

  // RAM as integrated: reset clears dataOut, dataOut holds while readEn is low
  always @(posedge clk) begin
    if (reset) dataOut <= 8'h00;
    else if (readEn) dataOut <= ramMem[readAddr];
    if (writeEn) ramMem[writeAddr] <= inData;
  end

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic r);
    inValid  = v;
    inData   = d;
    outReady = r;
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    tick();
    reset = 1'b0;
    #1;
  endtask

  logic [7:0] sb[$];
  int expMem;
  int writes;
  int received;
  int modelMem;
  logic modelOV;
  logic expWr;
  logic expRd;

  initial begin
    reset = 1'b1;
    inValid = 1'b0;
    outReady = 1'b0;
    inData = 8'h00;
    doReset();
    checkValue("reset_memCount", memCount, 0);
    checkValue("reset_outValid", outValid, 0);
    checkValue("reset_almostFull", almostFull, 0);
    checkValue("reset_empty", empty, 1);
    checkValue("reset_inReady", inReady, 1);

    // Fill: inValid held, outReady low for 20 cycles
    writes = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'(8'h10 + i), 1'b0);
      expMem = (i == 0) ? 0 : (i == 1) ? 1 : ((i - 1 > 16) ? 16 : i - 1);
      checkValue($sformatf("fill_memCount_%0d", i), memCount, expMem);
      checkValue($sformatf("fill_inReady_%0d", i), inReady, (expMem != 16));
      checkValue($sformatf("fill_almostFull_%0d", i), almostFull, (expMem >= 14));
      if (writeEn) writes++;
      $display("fill cycle %0d: writeEn=%0b memCount=%0d", i, writeEn, memCount);
      tick();
    end
    checkValue("fill_writes", writes, 17);
    checkValue("fill_outValid", outValid, 1);
    checkValue("fill_dataOut", dataOut, 8'h10);

    // Full, outReady pulsed for one cycle
    drive(1'b1, 8'hEE, 1'b1);
    checkValue("pulse_readEn", readEn, 1);
    checkValue("pulse_writeEn", writeEn, 0);
    checkValue("pulse_inReady", inReady, 0);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    checkValue("pulse_memCount", memCount, 15);
    checkValue("pulse_inReadyBack", inReady, 1);
    for (int i = 0; i < 3; i++) begin
      checkValue($sformatf("stall_dataOut_%0d", i), dataOut, 8'h11);
      checkValue($sformatf("stall_outValid_%0d", i), outValid, 1);
      tick();
    end
    $display("pulse: transferred 0x10, output stage now 0x%0h", dataOut);

    // Single flit through an empty FIFO
    doReset();
    drive(1'b1, 8'hA5, 1'b1);
    checkValue("single_c0_writeEn", writeEn, 1);
    checkValue("single_c0_readEn", readEn, 0);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    checkValue("single_c1_readEn", readEn, 1);
    checkValue("single_c1_memCount", memCount, 1);
    checkValue("single_c1_outValid", outValid, 0);
    tick();
    checkValue("single_c2_outValid", outValid, 1);
    checkValue("single_c2_dataOut", dataOut, 8'hA5);
    checkValue("single_c2_readEn", readEn, 0);
    $display("single: flit 0x%0h out in cycle 2", dataOut);
    tick();
    checkValue("single_c3_outValid", outValid, 0);
    checkValue("single_c3_empty", empty, 1);

    // Streaming 40 flits with both sides always ready
    doReset();
    sb.delete();
    received = 0;
    for (int i = 0; i < 50 && received < 40; i++) begin
      if (i < 40) drive(1'b1, 8'(8'h40 + i), 1'b1);
      else drive(1'b0, 8'h00, 1'b1);
      if (i < 40) begin
        checkValue($sformatf("stream_inReady_%0d", i), inReady, 1);
        checkValue($sformatf("stream_writeAddr_%0d", i), writeAddr, i % 16);
        checkValue($sformatf("stream_memCount_%0d", i), memCount, (i == 0) ? 0 : 1);
        if (i >= 1) checkValue($sformatf("stream_readAddr_%0d", i), readAddr, (i - 1) % 16);
        sb.push_back(8'(8'h40 + i));
      end
      if (outValid && outReady) begin
        if (sb.size() == 0) checkValue("stream_extra", 1, 0);
        else begin
          checkValue($sformatf("stream_data_%0d", received), dataOut, sb.pop_front());
          $display("stream: out #%0d data 0x%0h", received, dataOut);
        end
        received++;
      end
      tick();
    end
    checkValue("stream_received", received, 40);
    checkValue("stream_leftover", sb.size(), 0);

    // Random handshakes against a scoreboard
    doReset();
    sb.delete();
    modelMem = 0;
    modelOV = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      checkValue("rand_memCount", memCount, modelMem);
      checkValue("rand_outValid", outValid, modelOV);
      if (modelOV && outReady) begin
        if (sb.size() == 0) checkValue("rand_underflow", 1, 0);
        else checkValue("rand_data", dataOut, sb.pop_front());
      end
      expWr = inValid && (modelMem != 16);
      expRd = (modelMem != 0) && (!modelOV || outReady);
      if (expWr) sb.push_back(inData);
      modelMem = modelMem + int'(expWr) - int'(expRd);
      modelOV = expRd ? 1'b1 : (outReady ? 1'b0 : modelOV);
      tick();
    end
    $display("random: 10000 cycles, %0d flits left buffered", sb.size());

    // Reset with 9 flits in RAM and the output stage full
    doReset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'(8'h80 + i), 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0);
    checkValue("midrst_pre_memCount", memCount, 9);
    checkValue("midrst_pre_outValid", outValid, 1);
    reset = 1'b1;
    drive(1'b1, 8'h99, 1'b1);
    checkValue("midrst_inReady", inReady, 0);
    checkValue("midrst_writeEn", writeEn, 0);
    checkValue("midrst_readEn", readEn, 0);
    tick();
    reset = 1'b0;
    drive(1'b1, 8'h3C, 1'b1);
    checkValue("midrst_memCount", memCount, 0);
    checkValue("midrst_outValid", outValid, 0);
    checkValue("midrst_empty", empty, 1);
    checkValue("midrst_inReady_after", inReady, 1);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    checkValue("midrst_c1_outValid", outValid, 0);
    tick();
    checkValue("midrst_c2_outValid", outValid, 1);
    checkValue("midrst_c2_dataOut", dataOut, 8'h3C);
    $display("midrst: flit 0x%0h out 2 cycles after reset release", dataOut);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
